zxuno_uart_tx: RTL and testbench

- Serializing back end of the ZX-UNO UART register path.
- Accepts the one-cycle byte strobe produced when the CPU writes UARTDATA (0xC6).
- Buffers bytes in a small TX FIFO and shifts them out on txd as 8N1 frames.
- Honours the modem's CTS flow control and reports busy, full and overflow status for the UARTSTAT (0xC7) path.

---
 rtl/zxuno_uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/uart_tx_shifter.sv | 64 ++++++
 rtl/zxuno_uart_tx.sv | 53 +++++
 tb/tb_zxuno_uart_tx.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/zxuno_uart_pkg.sv
// zxuno_uart_pkg: shared constants for the ZX-UNO UART transmit path
package zxuno_uart_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;
    localparam logic [7:0] UARTDATA = 8'hC6;
    localparam logic [7:0] UARTSTAT = 8'hC7;
    localparam int DEFAULT_DIVISOR = 28;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign empty = count == '0;
    assign full = count[ADDR_WIDTH];
    assign push = wr_en && !full;
    assign pop = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    // storage array; no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    // pointers wrap modulo depth; count tracks push minus pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        end
    end
endmodule

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: baud timing, framing FSM and shift register for 8N1 output
module uart_tx_shifter import zxuno_uart_pkg::*; #(
    parameter int DIVISOR = DEFAULT_DIVISOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       cts_s,
    output logic       ready,
    output logic       txd,
    output logic       active
);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] RELOAD = CW'(DIVISOR - 1);
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic bit_end;
    assign bit_end = cnt == '0;
    assign active = state != ST_IDLE;
    // a new frame may only begin from idle or exactly at the end of a stop bit
    assign ready = valid && !cts_s && (state == ST_IDLE || (state == ST_STOP && bit_end));
    // frame sequencing; txd is registered so it changes together with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            txd <= 1'b1;
            cnt <= '0;
            shift <= '0;
            bit_idx <= '0;
        end else if (ready) begin
            state <= ST_START;
            txd <= 1'b0;
            shift <= data;
            cnt <= RELOAD;
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= RELOAD;
                if (state == ST_START) begin
                    state <= ST_DATA;
                    txd <= shift[0];
                    shift <= shift >> 1;
                    bit_idx <= '0;
                end else if (state == ST_DATA) begin
                    if (bit_idx == 3'd7) begin
                        state <= ST_STOP;
                        txd <= 1'b1;
                    end else begin
                        txd <= shift[0];
                        shift <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    state <= ST_IDLE;
                    txd <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/zxuno_uart_tx.sv
// zxuno_uart_tx: buffered 8N1 UART transmitter with CTS flow control
module zxuno_uart_tx import zxuno_uart_pkg::*; #(
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_bus,
    input  logic                  reset,
    input  logic [7:0]            uart_tx_data,
    input  logic                  uart_tx_req,
    input  logic                  cts_n,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_fifo_full,
    output logic [ADDR_WIDTH:0]   tx_fifo_count,
    output logic                  tx_overflow
);
    logic [1:0] cts_sync;
    logic cts_s, empty, pop, active;
    logic [7:0] head;
    assign cts_s = cts_sync[1];
    assign tx_busy = active || !empty;
    // two-flop synchronizer for the asynchronous CTS pin; resets to "not clear"
    always_ff @(posedge clk_bus) begin
        if (reset) cts_sync <= 2'b11;
        else cts_sync <= {cts_sync[0], cts_n};
    end
    // sticky record of any write dropped against a full FIFO
    always_ff @(posedge clk_bus) begin
        if (reset) tx_overflow <= 1'b0;
        else if (uart_tx_req && tx_fifo_full) tx_overflow <= 1'b1;
    end
    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
        .clk(clk_bus),
        .rst(reset),
        .wr_data(uart_tx_data),
        .wr_en(uart_tx_req),
        .rd_en(pop),
        .rd_data(head),
        .empty(empty),
        .full(tx_fifo_full),
        .count(tx_fifo_count)
    );
    uart_tx_shifter #(.DIVISOR(DIVISOR)) u_shifter (
        .clk(clk_bus),
        .rst(reset),
        .data(head),
        .valid(!empty),
        .cts_s(cts_s),
        .ready(pop),
        .txd(txd),
        .active(active)
    );
endmodule

// File: tb/tb_zxuno_uart_tx.sv
// tb_zxuno_uart_tx: directed and random stimulus checked against a frame-level model
module tb_zxuno_uart_tx;
    localparam int D = 4;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int FL = 10 * D;
    logic clk_bus = 1'b0;
    logic reset = 1'b1;
    logic uart_tx_req = 1'b0;
    logic cts_n = 1'b1;
    logic [7:0] uart_tx_data = 8'h00;
    logic txd, tx_busy, tx_fifo_full, tx_overflow;
    logic [AW:0] tx_fifo_count;
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q[$];
    bit m_act = 0;
    bit m_ovf = 0;
    bit m_c1 = 1;
    bit m_c2 = 1;
    int m_pos = 0;
    logic [7:0] m_byte = 8'h00;

    zxuno_uart_tx #(.DIVISOR(D), .ADDR_WIDTH(AW)) dut (
        .clk_bus(clk_bus),
        .reset(reset),
        .uart_tx_data(uart_tx_data),
        .uart_tx_req(uart_tx_req),
        .cts_n(cts_n),
        .txd(txd),
        .tx_busy(tx_busy),
        .tx_fifo_full(tx_fifo_full),
        .tx_fifo_count(tx_fifo_count),
        .tx_overflow(tx_overflow)
    );

    always #5 clk_bus = ~clk_bus;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // line level of bit slot k of a 10-slot 8N1 frame
    function automatic logic bit_at(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    endfunction

    // one clock edge of the reference: queue semantics plus frame position counter
    task automatic model_edge();
        int sz;
        bit go;
        logic [7:0] nb;
        nb = 8'h00;
        if (reset) begin
            q.delete();
            m_act = 0;
            m_ovf = 0;
            m_c1 = 1;
            m_c2 = 1;
            return;
        end
        sz = q.size();
        go = !m_c2 && sz > 0 && (!m_act || m_pos == FL - 1);
        if (go) nb = q.pop_front();
        if (uart_tx_req) begin
            if (sz < DEPTH) q.push_back(uart_tx_data);
            else m_ovf = 1;
        end
        if (go) begin
            m_act = 1;
            m_pos = 0;
            m_byte = nb;
        end else if (m_act) begin
            if (m_pos == FL - 1) m_act = 0;
            else m_pos++;
        end
        m_c2 = m_c1;
        m_c1 = cts_n;
    endtask

    task automatic step();
        @(posedge clk_bus);
        model_edge();
        #1;
        chk("txd", txd, m_act ? bit_at(m_byte, m_pos / D) : 1'b1);
        chk("busy", tx_busy, m_act || q.size() > 0);
        chk("count", tx_fifo_count, q.size());
        chk("full", tx_fifo_full, q.size() == DEPTH);
        chk("overflow", tx_overflow, m_ovf);
    endtask

    task automatic push(input logic [7:0] b);
        uart_tx_req = 1'b1;
        uart_tx_data = b;
        step();
        uart_tx_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        cts_n = 1'b0;
        idle(3);
        push(8'h55);
        idle(45);
        uart_tx_req = 1'b1;
        uart_tx_data = 8'hA5;
        step();
        uart_tx_data = 8'h3C;
        step();
        uart_tx_req = 1'b0;
        idle(85);
        cts_n = 1'b1;
        idle(3);
        for (int i = 0; i < 17; i++) push(8'(i));
        idle(5);
        cts_n = 1'b0;
        idle(16 * FL + 10);
        push(8'h81);
        push(8'h7E);
        idle(8);
        cts_n = 1'b1;
        idle(FL + 20);
        cts_n = 1'b0;
        idle(FL + 10);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        idle(10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(30);
        for (int i = 0; i < 4000; i++) begin
            uart_tx_req = $urandom_range(0, 5) == 0;
            uart_tx_data = 8'($urandom);
            if ($urandom_range(0, 199) == 0) cts_n = ~cts_n;
            reset = $urandom_range(0, 1499) == 0;
            step();
        end
        uart_tx_req = 1'b0;
        reset = 1'b0;
        cts_n = 1'b0;
        idle(DEPTH * FL + 20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
